// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared FSM states, READ opcode and frame bit counts for spi_flash_xip
package spi_flash_pkg;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, RESP, GAP} state_e;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         CMD_BITS  = 8;
   localparam int         ADDR_BITS = 24;
   localparam int         DATA_BITS = 32;
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/spi_flash_sclk_gen.sv
// spi_flash_sclk_gen: mode-0 SPI clock, CLK_DIV cycles per half-period, with one-cycle edge strobes
module spi_flash_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);
   logic [7:0] cnt_q;
   logic       sck_q;
   logic       wrap;
   assign wrap   = en_i && cnt_q == 8'(CLK_DIV - 1);
   assign rise_o = wrap && !sck_q;
   assign fall_o = wrap && sck_q;
   assign sck_o  = sck_q;
   // half-period counter; held at zero with sck low whenever disabled
   always_ff @(posedge clock) begin
      if (reset || !en_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= wrap ? '0 : cnt_q + 8'd1;
         sck_q <= sck_q ^ wrap;
      end
   end
endmodule

// File: rtl/spi_flash_xip.sv
// spi_flash_xip: execute-in-place SPI NOR word reader (03h read, 24-bit address, 32-bit little-endian word).
// Defining SPI_FLASH_XIP_CACHE_EN adds a one-entry word cache that answers repeat reads without SPI traffic.
module spi_flash_xip
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int GAP_CYC = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        sck,
   output logic        ss,
   output logic        mosi,
   input  logic        miso
);
   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] tx_q, rx_q, rsp_data_q, rx_next, hit_data;
   logic        ss_q, req_ready_q, rsp_valid_q;
   logic        fall, unused_rise, accept, done, hit, unused_addr_lsbs;
   assign accept           = req_valid && req_ready_q;
   assign rx_next          = {rx_q[30:0], miso};
   assign done             = state_q == DATA && fall && cnt_q == 8'(DATA_BITS - 1);
   assign unused_addr_lsbs = ^req_addr[1:0];
   assign req_ready        = req_ready_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign ss               = ss_q;
   assign mosi             = tx_q[31];
   spi_flash_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clock  (clock),
      .reset  (reset),
      .en_i   (!ss_q),
      .sck_o  (sck),
      .rise_o (unused_rise),
      .fall_o (fall)
   );
`ifdef SPI_FLASH_XIP_CACHE_EN
   logic        cache_valid_q;
   logic [21:0] cache_tag_q;
   logic [31:0] cache_data_q;
   assign hit      = cache_valid_q && cache_tag_q == req_addr[23:2];
   assign hit_data = cache_data_q;
   // entry is invalidated and retagged when a miss starts, then validated when its data completes
   always_ff @(posedge clock) begin
      if (reset) begin
         cache_valid_q <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
      end else if (accept && !hit) begin
         cache_valid_q <= 1'b0;
         cache_tag_q   <= req_addr[23:2];
      end else if (done) begin
         cache_valid_q <= 1'b1;
         cache_data_q  <= bswap32(rx_next);
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif
   // transaction sequencer; mosi is the MSB of a shifter that refills with ones, so DATA sends 1s
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tx_q        <= '1;
         rx_q        <= '0;
         ss_q        <= 1'b1;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= !accept;
               if (accept && hit) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= hit_data;
               end else if (accept) begin
                  state_q <= CMD;
                  ss_q    <= 1'b0;
                  cnt_q   <= '0;
                  tx_q    <= {CMD_READ, req_addr[23:2], 2'b00};
               end
            end
            CMD, ADDR, DATA: if (fall) begin
               tx_q  <= {tx_q[30:0], 1'b1};
               cnt_q <= cnt_q + 8'd1;
               if (state_q == DATA) rx_q <= rx_next;
               if (state_q == CMD && cnt_q == 8'(CMD_BITS - 1)) begin
                  state_q <= ADDR;
                  cnt_q   <= '0;
               end
               if (state_q == ADDR && cnt_q == 8'(ADDR_BITS - 1)) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
               end
               if (done) begin
                  state_q     <= RESP;
                  ss_q        <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= bswap32(rx_next);
               end
            end
            RESP: if (rsp_ready) begin
               state_q     <= GAP;
               rsp_valid_q <= 1'b0;
               cnt_q       <= '0;
            end
            GAP: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == 8'(GAP_CYC - 1)) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_xip.sv
// tb_spi_flash_xip: scoreboard bench, three spi_flash_xip instances (CLK_DIV 2/1/5) each on a behavioural 03h-read flash
module tb_spi_flash_xip;
   localparam int N   = 3;
   localparam int GAP = 4;
`ifdef SPI_FLASH_XIP_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   typedef struct {
      int          inst;
      int          t0;
      int          lat;
      logic [31:0] data;
      logic [31:0] cmd;
      bit          spi;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req_valid_a = '0;
   logic [N-1:0] rsp_ready_a = '0;
   logic [N-1:0] req_ready_a, rsp_valid_a, sck_a, ss_a, mosi_a;
   logic [23:0]  req_addr_a [N];
   logic [31:0]  rsp_data_a [N];
   logic [31:0]  cap_a [N];
   int           mbad_a [N], sbad_a [N], gap_a [N];
   logic [7:0]   mem [4096];
   exp_t         sb [$];
   int           total = 0, bad = 0, cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 2 : (g == 1) ? 1 : 5;
      logic        miso = 1'b0;
      logic        mosi_p = 1'b1;
      logic [31:0] cap = '0;
      int          bits = 0, hi_run = 0, gap = 0, mbad = 0, sbad = 0;
      spi_flash_xip #(.CLK_DIV(DIV), .GAP_CYC(GAP)) dut (
         .clock     (clock),
         .reset     (reset),
         .req_valid (req_valid_a[g]),
         .req_ready (req_ready_a[g]),
         .req_addr  (req_addr_a[g]),
         .rsp_valid (rsp_valid_a[g]),
         .rsp_ready (rsp_ready_a[g]),
         .rsp_data  (rsp_data_a[g]),
         .sck       (sck_a[g]),
         .ss        (ss_a[g]),
         .mosi      (mosi_a[g]),
         .miso      (miso)
      );
      // flash: shift command/address in on sck rise; framing restarts whenever ss goes high
      always @(posedge sck_a[g] or posedge ss_a[g]) begin
         if (ss_a[g]) bits = 0;
         else begin
            if (bits < 32) cap = {cap[30:0], mosi_a[g]};
            bits++;
         end
      end
      // flash: drive the next read bit after each falling edge once the address is complete
      always @(negedge sck_a[g]) begin
         if (bits >= 32 && bits < 64) begin
            automatic int k = bits - 32;
            automatic logic [7:0] b = mem[(int'(cap[11:0]) + k / 8) % 4096];
            miso = b[7 - k % 8];
         end
      end
      // bus monitor: sck quiet while deselected, mosi steady while sck high, length of ss-high runs
      always @(negedge clock) begin
         if (ss_a[g] && sck_a[g]) sbad++;
         if (sck_a[g] && mosi_a[g] !== mosi_p) mbad++;
         mosi_p = mosi_a[g];
         if (ss_a[g]) hi_run++;
         else begin
            if (hi_run > 0) gap = hi_run;
            hi_run = 0;
         end
      end
      assign cap_a[g]  = cap;
      assign mbad_a[g] = mbad;
      assign sbad_a[g] = sbad;
      assign gap_a[g]  = gap;
   end

   function automatic logic [31:0] word_at(input logic [23:0] a);
      int b = int'(a[11:0]) & ~3;
      return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input int i, input logic [23:0] a, input int lat, input logic [31:0] data,
                       input bit spi, input bit push);
      int   n = 0;
      exp_t e;
      req_addr_a[i]  = a;
      req_valid_a[i] = 1'b1;
      while (req_ready_a[i] !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL send_timeout inst=%0d req_ready=%b required=1", i, req_ready_a[i]);
      end
      e.inst = i;
      e.t0   = cyc;
      e.lat  = lat;
      e.data = data;
      e.cmd  = {8'h03, a[23:2], 2'b00};
      e.spi  = spi;
      if (push) sb.push_back(e);
      tick();
      req_valid_a[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int hold);
      exp_t e;
      int   n = 0;
      bit   ss_dropped = 1'b0;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty size=0 required>0");
         return;
      end
      e = sb.pop_front();
      while (rsp_valid_a[e.inst] !== 1'b1 && n < 2000) begin
         if (ss_a[e.inst] !== 1'b1) ss_dropped = 1'b1;
         tick();
         n++;
      end
      total++;
      if (cyc - e.t0 !== e.lat) begin
         bad++;
         $display("FAIL rsp_latency inst=%0d got=%0d want=%0d", e.inst, cyc - e.t0, e.lat);
      end
      total++;
      if (rsp_data_a[e.inst] !== e.data) begin
         bad++;
         $display("FAIL rsp_data inst=%0d got=%h want=%h", e.inst, rsp_data_a[e.inst], e.data);
      end
      total++;
      if ({ss_a[e.inst], sck_a[e.inst]} !== 2'b10) begin
         bad++;
         $display("FAIL rsp_bus_idle inst=%0d ss,sck=%b%b want=10", e.inst, ss_a[e.inst], sck_a[e.inst]);
      end
      total++;
      if (e.spi && cap_a[e.inst] !== e.cmd) begin
         bad++;
         $display("FAIL mosi_cmd_addr inst=%0d got=%h want=%h", e.inst, cap_a[e.inst], e.cmd);
      end else if (!e.spi && ss_dropped) begin
         bad++;
         $display("FAIL hit_no_spi inst=%0d ss_dropped=1 want=0", e.inst);
      end
      for (int k = 0; k < hold; k++) begin
         tick();
         total++;
         if ({rsp_valid_a[e.inst], rsp_data_a[e.inst]} !== {1'b1, e.data}) begin
            bad++;
            $display("FAIL rsp_hold inst=%0d valid=%b data=%h want 1/%h", e.inst, rsp_valid_a[e.inst],
                     rsp_data_a[e.inst], e.data);
         end
      end
      rsp_ready_a[e.inst] = 1'b1;
      tick();
      rsp_ready_a[e.inst] = 1'b0;
      total++;
      if (rsp_valid_a[e.inst] !== 1'b0) begin
         bad++;
         $display("FAIL rsp_release inst=%0d valid=%b want=0", e.inst, rsp_valid_a[e.inst]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++) begin
            total++;
            if ({ss_a[i], sck_a[i], rsp_valid_a[i], mosi_a[i], req_ready_a[i]} !== {4'b1001, k != 0} ||
                rsp_data_a[i] !== 32'h0) begin
               bad++;
               $display("FAIL reset_idle inst=%0d k=%0d ss,sck,rv,mosi,rdy=%b%b%b%b%b data=%h want 1001%b/0",
                        i, k, ss_a[i], sck_a[i], rsp_valid_a[i], mosi_a[i], req_ready_a[i], rsp_data_a[i], k != 0);
            end
         end
         tick();
      end
   endtask

   task automatic test_basic();
      send(0, 24'h000102, 257, 32'h44332211, 1'b1, 1'b1);
      wait_rsp(0);
   endtask

   task automatic test_back_to_back();
      send(0, 24'h000000, 257, word_at(24'h0), 1'b1, 1'b1);
      fork
         wait_rsp(10);
         send(0, 24'h000004, 257, word_at(24'h4), 1'b1, 1'b1);
      join
      wait_rsp(0);
      total++;
      if (gap_a[0] !== 10 + 1 + GAP + 1) begin
         bad++;
         $display("FAIL b2b_ss_gap got=%0d want=%0d", gap_a[0], 10 + 1 + GAP + 1);
      end
   endtask

   task automatic test_reset_mid();
      int  t0;
      bit  seen = 1'b0;
      send(0, 24'h000100, 0, 32'h0, 1'b1, 1'b0);
      t0 = cyc - 1;
      while (cyc < t0 + 50) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({ss_a[0], sck_a[0], cyc - t0} !== {2'b10, 32'd51}) begin
         bad++;
         $display("FAIL abort_bus ss,sck=%b%b at T0+%0d want 10 at T0+51", ss_a[0], sck_a[0], cyc - t0);
      end
      for (int k = 0; k < 300; k++) begin
         if (rsp_valid_a[0] !== 1'b0) seen = 1'b1;
         tick();
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL abort_no_rsp rsp_valid_seen=1 want=0");
      end
      send(0, 24'h000200, 257, word_at(24'h200), 1'b1, 1'b1);
      wait_rsp(0);
   endtask

   task automatic test_divs();
      send(1, 24'h000208, 129, word_at(24'h208), 1'b1, 1'b1);
      wait_rsp(0);
      send(2, 24'h000ffe, 641, word_at(24'hffc), 1'b1, 1'b1);
      wait_rsp(0);
   endtask

   task automatic test_repeat();
      send(0, 24'h000100, 257, 32'h44332211, 1'b1, 1'b1);
      wait_rsp(0);
      send(0, 24'h000100, CACHE ? 1 : 257, 32'h44332211, !CACHE, 1'b1);
      wait_rsp(0);
      send(0, 24'h000104, 257, word_at(24'h104), 1'b1, 1'b1);
      wait_rsp(2);
   endtask

   task automatic test_bus_rules();
      for (int i = 0; i < N; i++) begin
         total++;
         if (sbad_a[i] !== 0 || mbad_a[i] !== 0) begin
            bad++;
            $display("FAIL bus_rules inst=%0d sck_while_ss=%0d mosi_in_high=%0d want 0/0", i, sbad_a[i], mbad_a[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) req_addr_a[i] = '0;
      for (int a = 0; a < 4096; a++) mem[a] = 8'(a * 37 + 5);
      mem[256] = 8'h11;
      mem[257] = 8'h22;
      mem[258] = 8'h33;
      mem[259] = 8'h44;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid();
      test_divs();
      test_repeat();
      test_bus_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "bench timeout");
   end
endmodule
